seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Time-multiplexed driver for the board's 8-digit common-anode 7-segment display. It sits directly downstream of the display channel selector. It consumes the selected 32-bit `seg7_data` word, plus per-digit decimal-point and blank masks, and scans one hex digit per scan tick onto shared active-low segment lines. Input words are captured only at frame boundaries, so a digit never shows a mix of old and new data within one frame.

## Interface
Parameters:
- `CLK_DIV`, default 100000: clk cycles per digit slot. Legal range ≥ 2. 100000 gives a 1 kHz digit rate at 100 MHz.
- `BLINK_DIV`, default 64: frames per blink half-period. Used only with `SEG7_BLINK_EN`. Legal range ≥ 1.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `data_in`, in, 32: display word. Nibble i drives digit i. Digit 0 is rightmost and uses `data_in[3:0]`.
- `dp_in`, in, 8: decimal point enable per digit (1 = lit).
- `blank_in`, in, 8: blank per digit (1 = digit dark).
- `blink_in`, in, 8: blink enable per digit. Ignored without `SEG7_BLINK_EN`.
- `an`, out, 8: digit anode enables, active-low, one-hot-low when a digit is lit.
- `seg`, out, 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `dp`, out, 1: decimal point, active-low.
- `frame_sync`, out, 1: one-cycle pulse on the cycle the input snapshot is taken.

## Operation
- Prescaler `pcnt` counts 0..CLK_DIV-1 and wraps. `tick` is asserted when `pcnt == CLK_DIV-1`.
- Digit index `idx` (3 bits) has reset value 7. On each tick:
  - If `idx == 7`: this is a frame boundary. `idx <= 0`; shadow registers load `data_in`, `dp_in`, `blank_in` and `blink_in`; `frame_sync` pulses.
  - Otherwise: `idx <= idx+1`.
- Because `idx` resets to 7, the first tick after reset is a frame boundary. Shadow values are never displayed before being loaded.
- Output registers update on the tick cycle from the new `idx` and shadow values. For a boundary tick, this means the freshly captured data.
- The digit in slot k is lit when it is not blanked (and not blink-suppressed). Then:
  - `an = ~(8'b1 << k)`.
  - `seg` = hex decode of shadow nibble k.
  - `dp = ~shadow_dp[k]`.
- When slot k is blanked: `an = 8'hFF`, `seg = 7'h7F`, `dp = 1`.
- Hex decode values (`seg`, hex):
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
- Input changes between frame boundaries have no visible effect until the next boundary tick.

## Timing
- Reset values:
  - `an = 8'hFF`, `seg = 7'h7F`, `dp = 1`, `frame_sync = 0`.
  - `pcnt = 0`, `idx = 7`.
  - All shadow registers 0, blink phase 0.
- Reset deasserted at edge 0: the first tick occurs on the edge that samples `pcnt == CLK_DIV-1`, i.e. CLK_DIV cycles after reset release. Outputs remain at reset values until that edge.
- `an`, `seg` and `dp` change on the same clock edge. Each digit is held for exactly CLK_DIV cycles. A frame is 8·CLK_DIV cycles.
- Latency from `data_in` change to display: data sampled at the next boundary tick is visible on that same edge. Worst case is 8·CLK_DIV cycles.
- `frame_sync` is high for exactly one cycle, aligned with the boundary-tick output update.
- Asserting `rst` mid-frame forces all reset values immediately (asynchronously). Scanning restarts with a full CLK_DIV wait.

## Configuration
- Macro: `SEG7_BLINK_EN`.
- Defined:
  - A frame counter counts boundary ticks 0..BLINK_DIV-1 and toggles blink phase `bph` on wrap.
  - While `bph == 1`, any slot with `shadow_blink[k] = 1` is treated as blanked.
  - `bph` resets to 0 and changes only on boundary ticks.
- Undefined:
  - The frame counter and `bph` are not built.
  - `blink_in` remains a port but is unconnected internally.
  - Display behaviour is identical to a permanent `bph = 0`.

## Test plan
All scenarios use CLK_DIV=4.
- **Reset and first frame.** Reset, then `data_in = 32'h76543210`, masks 0. Expect outputs stay `FF/7F/1` for 4 cycles. On the first tick expect `frame_sync = 1`, `an = FE`, `seg = 40`. Then every 4 cycles expect `an` FD/FB/…/7F with `seg` 79, 24, 30, 19, 12, 02, 78.
- **Mid-frame update.** Change `data_in` to `32'hFEDCBA98` while `idx = 3`. Expect digits 4–7 still show 4–7. At the next boundary expect `seg = 00` (digit 0 = 8), then 10, 08, 03, 46, 21, 06, 0E.
- **Masks.** `dp_in = 8'h05`, `blank_in = 8'h02`. Expect `dp = 0` in slots 0 and 2. Expect slot 1 shows `an = FF`, `seg = 7F`, `dp = 1`.
- **Reset mid-frame.** Assert `rst` during slot 5 for one cycle. Expect immediate `an = FF`. Expect the next `frame_sync` exactly 4 cycles after release, with slot 0 lit.
- **Blink (`SEG7_BLINK_EN`, BLINK_DIV=2).** `blink_in = 8'h01`. Expect digit 0 lit in frames 1–2, dark (`an = FF`) in frames 3–4, and lit again in frame 5. Other digits are unaffected.
- **Blink disabled (macro undefined).** Same stimulus as the blink scenario. Expect digit 0 lit in every frame.

Source files
------------

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Time-multiplexed driver for an 8-digit common-anode 7-segment
//            display. One hex digit is scanned per CLK_DIV-cycle slot onto
//            shared active-low segment lines. Inputs are snapshotted only at
//            frame boundaries so a frame never mixes old and new data.
// Options  : define SEG7_BLINK_EN to build per-digit blinking (BLINK_DIV
//            frames per half-period); without it blink_in is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
  parameter int CLK_DIV   = 100000,
  parameter int BLINK_DIV = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  blank_in,
  input  logic [7:0]  blink_in,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_sync
);

  localparam int              c_PW   = $clog2(CLK_DIV);
  localparam logic [c_PW-1:0] c_PMAX = c_PW'(CLK_DIV - 1);

  // Hex digit to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [c_PW-1:0] r_pcnt;
  logic [2:0]      r_idx;
  logic [31:0]     r_sh_data;
  logic [7:0]      r_sh_dp;
  logic [7:0]      r_sh_blank;

  logic            w_tick;
  logic            w_boundary;
  logic [2:0]      w_idx_nxt;
  logic [31:0]     w_data;
  logic [7:0]      w_dpm;
  logic [7:0]      w_blankm;
  logic [3:0]      w_nib;
  logic            w_supp;
  logic            w_dark;
  logic [7:0]      w_an;
  logic [6:0]      w_seg;
  logic            w_dp;

  assign w_tick     = (r_pcnt == c_PMAX);
  assign w_boundary = w_tick && (r_idx == 3'd7);
  // idx wraps 7 -> 0 naturally, so the boundary case needs no special path
  assign w_idx_nxt  = r_idx + 3'd1;

  // On a boundary tick the freshly captured inputs are displayed immediately
  assign w_data   = w_boundary ? data_in  : r_sh_data;
  assign w_dpm    = w_boundary ? dp_in    : r_sh_dp;
  assign w_blankm = w_boundary ? blank_in : r_sh_blank;
  assign w_nib    = w_data[{w_idx_nxt, 2'b00} +: 4];

`ifdef SEG7_BLINK_EN
  localparam int              c_FW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [c_FW-1:0] c_FMAX = c_FW'(BLINK_DIV - 1);

  logic [c_FW-1:0] r_fcnt;
  logic            r_bph;
  logic            r_sh_bph;
  logic [7:0]      r_sh_blink;

  // Frame counter toggles the blink phase; a frame displays the phase that
  // was current when it started, so all its slots agree on blink state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fcnt     <= '0;
      r_bph      <= 1'b0;
      r_sh_bph   <= 1'b0;
      r_sh_blink <= 8'h00;
    end else if (w_boundary) begin
      r_sh_blink <= blink_in;
      r_sh_bph   <= r_bph;
      if (r_fcnt == c_FMAX) begin
        r_fcnt <= '0;
        r_bph  <= ~r_bph;
      end else begin
        r_fcnt <= r_fcnt + c_FW'(1);
      end
    end
  end

  assign w_supp = w_boundary ? (r_bph    & blink_in[w_idx_nxt])
                             : (r_sh_bph & r_sh_blink[w_idx_nxt]);
`else
  logic w_unused_blink;
  assign w_unused_blink = ^blink_in;
  assign w_supp         = 1'b0;
`endif

  assign w_dark = w_blankm[w_idx_nxt] | w_supp;

  // Next display values for the slot being entered
  always_comb begin
    w_an  = 8'hFF;
    w_seg = 7'h7F;
    w_dp  = 1'b1;
    if (!w_dark) begin
      w_an  = ~(8'b1 << w_idx_nxt);
      w_seg = hex7(w_nib);
      w_dp  = ~w_dpm[w_idx_nxt];
    end
  end

  // Prescaler: one tick every CLK_DIV cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + c_PW'(1);
    end
  end

  // Slot advance, boundary snapshot and registered display outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx      <= 3'd7;
      r_sh_data  <= 32'h0;
      r_sh_dp    <= 8'h00;
      r_sh_blank <= 8'h00;
      an         <= 8'hFF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_sync <= 1'b0;
    end else begin
      frame_sync <= w_boundary;
      if (w_tick) begin
        r_idx <= w_idx_nxt;
        an    <= w_an;
        seg   <= w_seg;
        dp    <= w_dp;
      end
      if (w_boundary) begin
        r_sh_data  <= data_in;
        r_sh_dp    <= dp_in;
        r_sh_blank <= blank_in;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Purpose  : Directed self-checking bench for seg7_scan_driver (CLK_DIV=4,
//            BLINK_DIV=2). Blink expectations follow SEG7_BLINK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst;
  logic [31:0] data_in;
  logic [7:0]  dp_in;
  logic [7:0]  blank_in;
  logic [7:0]  blink_in;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_sync;

  int checks = 0;
  int errors = 0;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan_driver #(.CLK_DIV(4), .BLINK_DIV(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .blink_in   (blink_in),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_sync (frame_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] e_an, input logic [6:0] e_seg,
                         input logic e_dp, input logic e_fs);
    chk({tag, ".an"},  {24'h0, an},        {24'h0, e_an});
    chk({tag, ".seg"}, {25'h0, seg},       {25'h0, e_seg});
    chk({tag, ".dp"},  {31'h0, dp},        {31'h0, e_dp});
    chk({tag, ".fs"},  {31'h0, frame_sync}, {31'h0, e_fs});
  endtask

  initial begin
    logic [7:0] e_an0;
    rst      = 1'b1;
    data_in  = 32'h76543210;
    dp_in    = 8'h00;
    blank_in = 8'h00;
    blink_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Reset state and the CLK_DIV wait before the first tick
    chk_out("reset", 8'hFF, 7'h7F, 1'b1, 1'b0);
    step(3);
    chk_out("pre_tick", 8'hFF, 7'h7F, 1'b1, 1'b0);
    step(1);
    chk_out("first_tick", 8'hFE, 7'h40, 1'b1, 1'b1);
    step(1);
    chk_out("slot0_hold", 8'hFE, 7'h40, 1'b1, 1'b0);
    step(3);
    chk_out("slot1", 8'hFD, 7'h79, 1'b1, 1'b0);
    for (int k = 2; k < 8; k++) begin
      step(4);
      chk_out($sformatf("f1_slot%0d", k), ~(8'b1 << k), hex_tab[k], 1'b1, 1'b0);
    end

    // Second frame; change data while slot 3 is showing
    step(4);
    chk_out("f2_slot0", 8'hFE, 7'h40, 1'b1, 1'b1);
    step(12);
    chk_out("f2_slot3", 8'hF7, 7'h30, 1'b1, 1'b0);
    data_in = 32'hFEDCBA98;
    for (int k = 4; k < 8; k++) begin
      step(4);
      chk_out($sformatf("f2_old_slot%0d", k), ~(8'b1 << k), hex_tab[k], 1'b1, 1'b0);
    end
    // Masks applied mid-frame take effect at the frame after next boundary
    for (int k = 0; k < 8; k++) begin
      step(4);
      chk_out($sformatf("f3_new_slot%0d", k), ~(8'b1 << k), hex_tab[k + 8], 1'b1, k == 0);
    end
    dp_in    = 8'h05;
    blank_in = 8'h02;
    step(4);
    chk_out("mask_slot0", 8'hFE, 7'h00, 1'b0, 1'b1);
    step(4);
    chk_out("mask_slot1", 8'hFF, 7'h7F, 1'b1, 1'b0);
    step(4);
    chk_out("mask_slot2", 8'hFB, 7'h08, 1'b0, 1'b0);
    step(4);
    chk_out("mask_slot3", 8'hF7, 7'h03, 1'b1, 1'b0);
    step(8);
    chk_out("slot5", 8'hDF, 7'h21, 1'b1, 1'b0);

    // Asynchronous reset in slot 5, then a full CLK_DIV wait
    #2;
    rst = 1'b1;
    #1;
    chk_out("async_rst", 8'hFF, 7'h7F, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(3);
    chk_out("rst_wait", 8'hFF, 7'h7F, 1'b1, 1'b0);
    step(1);
    chk_out("rst_first", 8'hFE, 7'h00, 1'b0, 1'b1);

    // Blink on digit 0 from a fresh reset
    rst      = 1'b1;
    data_in  = 32'h76543210;
    dp_in    = 8'h00;
    blank_in = 8'h00;
    blink_in = 8'h01;
    #1;
    @(negedge clk);
    rst = 1'b0;
    step(4);
    for (int f = 1; f <= 5; f++) begin
`ifdef SEG7_BLINK_EN
      e_an0 = (f == 3 || f == 4) ? 8'hFF : 8'hFE;
`else
      e_an0 = 8'hFE;
`endif
      chk($sformatf("blink_f%0d_an0", f), {24'h0, an}, {24'h0, e_an0});
      chk($sformatf("blink_f%0d_fs", f), {31'h0, frame_sync}, 32'h1);
      step(4);
      chk_out($sformatf("blink_f%0d_slot1", f), 8'hFD, 7'h79, 1'b1, 1'b0);
      step(28);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
